// File: rtl/grid_row_streamer.sv
// grid_row_streamer: snapshots a WIDTH x HEIGHT life grid and streams it out
// one row per valid/ready transfer. Optional GRID_POPCOUNT_EN adds pop_count.
module grid_row_streamer #(
    parameter int WIDTH  = 16,
    parameter int HEIGHT = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH*HEIGHT-1:0]   grid_in,
    input  logic                      frame_req,
    output logic                      busy,
    output logic [WIDTH-1:0]          row_data,
    output logic [$clog2(HEIGHT)-1:0] row_idx,
    output logic                      row_last,
    output logic                      row_valid,
    input  logic                      row_ready,
    output logic                      frame_done
`ifdef GRID_POPCOUNT_EN
    ,
    output logic [$clog2(WIDTH*HEIGHT+1)-1:0] pop_count
`endif
);

    localparam int IW = $clog2(HEIGHT);
    localparam logic [IW-1:0] LAST = IW'(HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                        state_q;
    logic [HEIGHT-1:0][WIDTH-1:0]  snap_q;
    logic [IW-1:0]                 row_idx_q;
    logic [IW-1:0]                 row_idx_d;
    logic [WIDTH-1:0]              row_data_q;
    logic                          row_valid_q;
    logic                          row_last_q;
    logic                          busy_q;
    logic                          frame_done_q;

`ifdef GRID_POPCOUNT_EN
    localparam int PW = $clog2(WIDTH*HEIGHT+1);

    logic [PW-1:0] pop_q;
    logic [PW-1:0] pop_d;

    function automatic logic [PW-1:0] popc(input logic [WIDTH-1:0] v);
        logic [PW-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + PW'(v[i]);
        end
        return c;
    endfunction

    // Running cell count including the row currently on offer
    always_comb begin
        pop_d = pop_q + popc(row_data_q);
    end

    assign pop_count = pop_q;
`endif

    // Next row index when the current row is accepted
    always_comb begin
        row_idx_d = row_idx_q + 1'b1;
    end

    // Frame FSM; every output is a register updated here
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            snap_q       <= '0;
            row_idx_q    <= '0;
            row_data_q   <= '0;
            row_valid_q  <= 1'b0;
            row_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef GRID_POPCOUNT_EN
            pop_q        <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (frame_req) begin
                        state_q     <= SEND;
                        snap_q      <= grid_in;
                        row_idx_q   <= '0;
                        row_data_q  <= grid_in[WIDTH-1:0];
                        row_valid_q <= 1'b1;
                        row_last_q  <= (LAST == '0);
                        busy_q      <= 1'b1;
`ifdef GRID_POPCOUNT_EN
                        pop_q       <= '0;
`endif
                    end
                end
                SEND: begin
                    if (row_ready) begin
`ifdef GRID_POPCOUNT_EN
                        pop_q <= pop_d;
`endif
                        if (row_idx_q == LAST) begin
                            state_q      <= DONE;
                            row_valid_q  <= 1'b0;
                            row_last_q   <= 1'b0;
                            frame_done_q <= 1'b1;
                        end else begin
                            row_idx_q  <= row_idx_d;
                            row_data_q <= snap_q[row_idx_d];
                            row_last_q <= (row_idx_d == LAST);
                        end
                    end
                end
                DONE: begin
                    state_q      <= IDLE;
                    frame_done_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign row_data   = row_data_q;
    assign row_idx    = row_idx_q;
    assign row_last   = row_last_q;
    assign row_valid  = row_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_grid_row_streamer.sv
// tb_grid_row_streamer: directed and randomized frames against a row-list
// reference model (rows sliced from the captured grid, $countones popcount).
module tb_grid_row_streamer;

    localparam int W = 16;
    localparam int H = 16;

    logic             clk;
    logic             reset;
    logic [W*H-1:0]   grid_in;
    logic             frame_req;
    logic             busy;
    logic [W-1:0]     row_data;
    logic [3:0]       row_idx;
    logic             row_last;
    logic             row_valid;
    logic             row_ready;
    logic             frame_done;
`ifdef GRID_POPCOUNT_EN
    logic [8:0]       pop_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    grid_row_streamer #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk       (clk),
        .reset     (reset),
        .grid_in   (grid_in),
        .frame_req (frame_req),
        .busy      (busy),
        .row_data  (row_data),
        .row_idx   (row_idx),
        .row_last  (row_last),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .frame_done(frame_done)
`ifdef GRID_POPCOUNT_EN
        ,
        .pop_count (pop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W*H-1:0] rand_grid();
        logic [W*H-1:0] g;
        for (int i = 0; i < W*H/32; i++) g[32*i +: 32] = $urandom;
        return g;
    endfunction

    // Entered and left at posedge+1 with the DUT idle.
    task automatic run_frame(input logic [W*H-1:0] g, input int srow,
                             input int slen, input bit rnd,
                             input int mut_at, input int req_at);
        logic [W*H-1:0] snap;
        int r;
        int cyc;
        int stalled;
        bit rdy;
        snap      = g;
        grid_in   = g;
        frame_req = 1'b1;
        @(posedge clk); #1;
        frame_req = 1'b0;
        r = 0;
        cyc = 0;
        stalled = 0;
        while (r < H && cyc < H + slen + 64) begin
            if (cyc == mut_at) grid_in = '1;
            frame_req = (cyc == req_at);
            rdy = 1'b1;
            if (r == srow && stalled < slen) begin
                rdy = 1'b0;
                stalled++;
            end else if (rnd && $urandom_range(0, 3) == 0) begin
                rdy = 1'b0;
            end
            row_ready = rdy;
            @(negedge clk);
            chk("valid", 32'(row_valid), 1);
            chk("idx", 32'(row_idx), r);
            chk("data", 32'(row_data), 32'(snap[r*W +: W]));
            chk("last", 32'(row_last), 32'(r == H - 1));
            chk("busy", 32'(busy), 1);
            chk("done_early", 32'(frame_done), 0);
            @(posedge clk); #1;
            if (rdy) r++;
            cyc++;
        end
        chk("timeout", r, H);
        frame_req = 1'b0;
        row_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("done", 32'(frame_done), 1);
        chk("done_valid", 32'(row_valid), 0);
        chk("done_busy", 32'(busy), 1);
        chk("done_last", 32'(row_last), 0);
`ifdef GRID_POPCOUNT_EN
        chk("pop", 32'(pop_count), $countones(snap));
`endif
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_done", 32'(frame_done), 0);
        chk("idle_valid", 32'(row_valid), 0);
        chk("idle_busy", 32'(busy), 0);
        @(posedge clk); #1;
        chk("no_second", 32'(busy), 0);
    endtask

    logic [W*H-1:0] pat;

    initial begin
        reset     = 1'b1;
        frame_req = 1'b1;
        row_ready = 1'b0;
        grid_in   = '1;
        pat       = {4{64'h0412_6424_0034_3C28}};

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_valid", 32'(row_valid), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_done", 32'(frame_done), 0);
            chk("rst_last", 32'(row_last), 0);
            chk("rst_data", 32'(row_data), 0);
            chk("rst_idx", 32'(row_idx), 0);
        end
        @(posedge clk); #1;
        reset     = 1'b0;
        frame_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_busy", 32'(busy), 0);
            chk("post_rst_valid", 32'(row_valid), 0);
        end
        @(posedge clk); #1;

        run_frame(pat, -1, 0, 1'b0, -1, -1);
`ifdef GRID_POPCOUNT_EN
        chk("pop68", 32'(pop_count), 68);
`endif

        run_frame(pat, 5, 3, 1'b0, -1, -1);

        run_frame(pat, -1, 0, 1'b0, 1, 7);
        run_frame('1, -1, 0, 1'b0, -1, -1);

        grid_in   = rand_grid();
        frame_req = 1'b1;
        row_ready = 1'b1;
        @(posedge clk); #1;
        frame_req = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_valid", 32'(row_valid), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(frame_done), 0);
        chk("arst_idx", 32'(row_idx), 0);
        chk("arst_data", 32'(row_data), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("no_resume_done", 32'(frame_done), 0);
            chk("no_resume_valid", 32'(row_valid), 0);
        end
        @(posedge clk); #1;

        run_frame(rand_grid(), -1, 0, 1'b0, -1, -1);
        for (int i = 0; i < 4; i++) begin
            run_frame(rand_grid(), int'($urandom_range(0, H - 1)),
                      int'($urandom_range(0, 4)), 1'b1, -1,
                      int'($urandom_range(0, 10)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/grid_row_streamer.md
# grid_row_streamer

Reads the 256-bit evolved grid produced by the life-grid `datapath` and streams it out one 16-bit row per transfer over a valid/ready handshake. The grid is snapshotted at frame start, so the datapath may keep evolving while a frame drains. Downstream consumers (display scan driver, debug UART bridge) take rows in order, starting with row 0 = `grid_in[15:0]`.

## Interface

- `WIDTH`, default 16: cells per row (row word width).
- `HEIGHT`, default 16: rows per grid; grid vector width is WIDTH*HEIGHT.
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `grid_in`  in  WIDTH*HEIGHT  live grid from `datapath` (`grid_evolve`); row r = bits [WIDTH*r+WIDTH-1 : WIDTH*r].
- `frame_req`  in  1  start-of-frame request; sampled only in IDLE.
- `busy`  out  1  high from the cycle after capture through the DONE cycle.
- `row_data`  out  WIDTH  current row word from the snapshot.
- `row_idx`  out  $clog2(HEIGHT)  index of the row on `row_data`.
- `row_last`  out  1  high while `row_valid` is high and `row_idx` = HEIGHT-1.
- `row_valid`  out  1  row word offered.
- `row_ready`  in  1  consumer accepts the word; a transfer is `row_valid && row_ready` at a rising edge.
- `frame_done`  out  1  one-cycle pulse after the last row transfers.

## Operation

- States: IDLE, SEND, DONE.
- IDLE: `row_valid`=0, `busy`=0. On an edge with `frame_req`=1:
  - copy `grid_in` into the snapshot register;
  - clear the row counter to 0;
  - go to SEND.
- SEND: `row_valid`=1, `row_data` = snapshot row `row_idx`, `busy`=1.
  - On a transfer with `row_idx` < HEIGHT-1: increment `row_idx`.
  - On a transfer with `row_idx` = HEIGHT-1: go to DONE.
  - Without a transfer: `row_data` and `row_idx` hold stable. The `row_valid` signal never drops mid-frame.
- DONE: `frame_done`=1, `busy`=1, `row_valid`=0 for exactly one cycle, then IDLE.
- `frame_req` in SEND or DONE is ignored. It is not queued and does not affect the snapshot.
- `grid_in` changes after capture do not affect the frame in progress.
- The row counter counts to exactly HEIGHT-1. No wrap into row 0 within a frame.
- `row_ready` is ignored outside SEND.
- Reset (any time, including mid-frame):
  - asynchronously forces IDLE;
  - clears the snapshot, `row_idx`, and `row_data` to 0;
  - drives `row_valid`, `row_last`, `busy`, and `frame_done` to 0;
  - discards the partial frame. Nothing resumes after reset is released.

## Timing

- Request at edge k: row 0 is valid in cycle k+1, i.e. capture latency is 1 cycle.
- With `row_ready` held high: rows 0..HEIGHT-1 occupy cycles k+1..k+HEIGHT, one row per cycle.
- `frame_done` is high in cycle k+HEIGHT+1.
- IDLE is re-entered at cycle k+HEIGHT+2. The earliest next capture is at the edge ending that cycle.
- Each stall cycle (`row_ready`=0 while valid) adds exactly one cycle.
- All outputs are registered or decoded from state only. There are no combinational paths from `row_ready` or `frame_req` to any output.

## Configuration

- `GRID_POPCOUNT_EN` defined:
  - adds output `pop_count`, width $clog2(WIDTH*HEIGHT+1) (9 bits at default);
  - the accumulator clears on capture and adds the popcount of each transferred row;
  - the value is valid and stable from the `frame_done` cycle until the next capture;
  - reset value is 0.
- `GRID_POPCOUNT_EN` undefined: no port, no accumulator logic. All other behaviour is identical.

## Test plan

- Reset held 4 cycles with `frame_req`=1 -> all outputs 0. After release with `frame_req`=0, `busy` stays 0.
- Capture with `row_ready` always 1:
  - stimulus: `grid_in` = {4{64'h0412_6424_0034_3C28}}, `frame_req` pulsed at edge k;
  - rows 0..3 = 16'h3C28, 16'h0034, 16'h6424, 16'h0412, repeating through row 15, in cycles k+1..k+16;
  - `row_last` high only in cycle k+16; `frame_done` high only in cycle k+17;
  - with `GRID_POPCOUNT_EN`, `pop_count` = 68.
- Backpressure: `row_ready` low for 3 cycles while row 5 is offered -> `row_data`/`row_idx` hold 16'h0034/5 for all 3 cycles, and `frame_done` is delayed by exactly 3 cycles.
- Snapshot isolation: flip `grid_in` to all-ones in cycle k+2 and pulse `frame_req` in cycle k+8 -> the frame still carries the original pattern and no second frame starts. A new request in IDLE then streams 16'hFFFF rows.
- Reset at cycle k+7 mid-frame -> `row_valid`, `busy`, and `frame_done` drop asynchronously and `frame_done` never pulses. A fresh request starts again at row 0.
